// File: rtl/mem_bus_pkg.sv
// Shared types for the memory-port controller: FSM states and access sizes.
// The decoder uses mem_size_t as well, so the encoding is fixed.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        ERR
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } mem_size_t;

    localparam int WAIT_W = 8;

    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Avalon-style memory master bus between mem_bus_ctrl and the memory slave.
interface mem_bus_ctrl_if;

    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
        output avm_readdata, avm_waitrequest
    );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane logic: byte enables, store replication, load extraction
// and extension, and alignment checking for one access.
module mem_lane_align
    import mem_bus_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  mem_size_t   size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] readdata,
    output logic [3:0]  byteenable,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [31:0] shifted;

    assign shifted = readdata >> {addr_lo, 3'b000};

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        byteenable = 4'b0000;
        wdata_rep  = wdata;
        rdata_ext  = readdata;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                byteenable = 4'b0001 << addr_lo;
                wdata_rep  = {4{wdata[7:0]}};
                rdata_ext  = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                byteenable = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep  = {2{wdata[15:0]}};
                rdata_ext  = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
                misaligned = addr_lo[0];
            end
            SZ_WORD: begin
                byteenable = 4'b1111;
                misaligned = (addr_lo != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Multicycle memory-port controller: arbitrates fetch/data requests onto one
// Avalon master, holds commands through waitrequest, and latches halting errors.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [1:0]  data_size,
    input  logic        data_signed,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        stall,
    output logic        addr_err,
    output logic        bus_err,
    mem_bus_ctrl_if.master bus
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    mem_state_t          state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [1:0]          lat_lo;
    mem_size_t           lat_size;
    logic                lat_signed;

    logic                req_any;
    logic [31:0]         req_addr;
    mem_size_t           req_size;
    logic                req_we;
    logic                req_signed;

    logic                in_idle;
    logic [1:0]          al_lo;
    mem_size_t           al_size;
    logic                al_signed;
    logic [3:0]          be;
    logic [31:0]         wdata_rep;
    logic [31:0]         rdata_ext;
    logic                misaligned;

    // Data access has priority; a fetch is always an unsigned word load.
    assign req_any    = fetch_req | data_req;
    assign req_addr   = data_req ? data_addr : fetch_addr;
    assign req_size   = data_req ? mem_size_t'(data_size) : SZ_WORD;
    assign req_we     = data_req & data_we;
    assign req_signed = data_req & data_signed;

    // Lane logic sees the live request while launching, the latched copy afterwards.
    assign in_idle   = (state == IDLE);
    assign al_lo     = in_idle ? req_addr[1:0] : lat_lo;
    assign al_size   = in_idle ? req_size      : lat_size;
    assign al_signed = in_idle ? req_signed    : lat_signed;

    mem_lane_align u_align (
        .addr_lo    (al_lo),
        .size       (al_size),
        .sign_ext   (al_signed),
        .wdata      (data_wdata),
        .readdata   (bus.avm_readdata),
        .byteenable (be),
        .wdata_rep  (wdata_rep),
        .rdata_ext  (rdata_ext),
        .misaligned (misaligned)
    );

    assign stall = (state == ERR) | (req_any & (state != RESP));

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            wait_cnt           <= '0;
            lat_lo             <= 2'b00;
            lat_size           <= SZ_BYTE;
            lat_signed         <= 1'b0;
            rdata              <= '0;
            done               <= 1'b0;
            addr_err           <= 1'b0;
            bus_err            <= 1'b0;
            bus.avm_address    <= '0;
            bus.avm_read       <= 1'b0;
            bus.avm_write      <= 1'b0;
            bus.avm_byteenable <= '0;
            bus.avm_writedata  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        lat_lo     <= req_addr[1:0];
                        lat_size   <= req_size;
                        lat_signed <= req_signed;
                        if (misaligned) begin
                            addr_err <= 1'b1;
                            state    <= ERR;
                        end else begin
                            wait_cnt           <= '0;
                            bus.avm_address    <= word_addr(req_addr);
                            bus.avm_read       <= ~req_we;
                            bus.avm_write      <= req_we;
                            bus.avm_byteenable <= be;
                            bus.avm_writedata  <= wdata_rep;
                            state              <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!bus.avm_waitrequest) begin
                        bus.avm_read  <= 1'b0;
                        bus.avm_write <= 1'b0;
                        rdata         <= rdata_ext;
                        done          <= 1'b1;
                        state         <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == WAIT_LAST) begin
                            bus.avm_read  <= 1'b0;
                            bus.avm_write <= 1'b0;
                            bus_err       <= 1'b1;
                            state         <= ERR;
                        end
                    end
                end
                RESP:    state <= IDLE;
                default: state <= ERR;
            endcase
        end
    end

endmodule
